// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: hazard-relevant fields from ID/EX/MEM in, stage
// enables, flushes, forwarding selects and status counters out.
interface pipe_ctrl_if;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        id_use1;
  logic        id_use2;
  logic        id_halt;
  logic [3:0]  ex_rd;
  logic        ex_wen;
  logic        ex_load;
  logic [3:0]  mem_rd;
  logic        mem_wen;
  logic        ex_br_taken;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Pipeline datapath side: supplies stage information, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, id_halt,
           ex_rd, ex_wen, ex_load, mem_rd, mem_wen, ex_br_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, halted, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, id_halt,
           ex_rd, ex_wen, ex_load, mem_rd, mem_wen, ex_br_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use / data-hazard stalls,
// taken-branch flushes, operand forwarding and HLT drain sequencing.
// Build option: define PIPE_CTRL_FWD_EN to enable EX/MEM and MEM/WB
// forwarding; without it every EX or MEM register match stalls ID.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, DRAIN, HALT} state_t;

`ifdef PIPE_CTRL_FWD_EN
  localparam state_t STALL_NEXT = LDSTALL;
`else
  localparam state_t STALL_NEXT = RUN;
`endif

  state_t      state;
  logic [1:0]  drain_cnt;
  logic        halted_q;
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic load_use, stall_req;
  logic br_ev, stall_ev, halt_ev, drain_ev;
  logic [1:0] fwd_a, fwd_b;

  // A source hazards against a stage only if it is really read and the
  // stage really writes a non-zero register.
  function automatic logic hit(input logic use_src, input logic [3:0] rs,
                               input logic wen, input logic [3:0] rd);
    return use_src && wen && (rd == rs) && (rd != 4'd0);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ex_hit1  = hit(bus.id_use1, bus.id_rs1, bus.ex_wen,  bus.ex_rd);
  assign ex_hit2  = hit(bus.id_use2, bus.id_rs2, bus.ex_wen,  bus.ex_rd);
  assign mem_hit1 = hit(bus.id_use1, bus.id_rs1, bus.mem_wen, bus.mem_rd);
  assign mem_hit2 = hit(bus.id_use2, bus.id_rs2, bus.mem_wen, bus.mem_rd);
  assign load_use = (ex_hit1 || ex_hit2) && bus.ex_load;

`ifdef PIPE_CTRL_FWD_EN
  assign stall_req = load_use;
`else
  // Without bypass paths a load match is just one kind of EX match.
  assign stall_req = load_use || ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
`endif

  // Prioritised per-cycle events; all forced idle while reset is low so
  // no control output can leave its reset value.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    br_ev    = 1'b0;
    stall_ev = 1'b0;
    halt_ev  = 1'b0;
    drain_ev = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (rst_n && state != HALT) begin
      br_ev    = bus.ex_br_taken;
      // LDSTALL is the single bubble already taken; DRAIN has a bubble in ID.
      stall_ev = !br_ev && state == RUN && stall_req;
      halt_ev  = !br_ev && !stall_ev && state != DRAIN && bus.id_halt;
      drain_ev = !br_ev && state == DRAIN;
`ifdef PIPE_CTRL_FWD_EN
      // The younger EX/MEM result wins over MEM/WB when both match.
      fwd_a = ex_hit1 ? 2'b01 : (mem_hit1 ? 2'b10 : 2'b00);
      fwd_b = ex_hit2 ? 2'b01 : (mem_hit2 ? 2'b10 : 2'b00);
`endif
    end
  end

  assign bus.pc_en       = !(stall_ev || halt_ev || drain_ev || state == HALT);
  assign bus.if_id_en    = !(stall_ev || state == HALT);
  assign bus.if_id_flush = br_ev || halt_ev || drain_ev;
  assign bus.id_ex_flush = br_ev || stall_ev;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.halted      = halted_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

  // Controller FSM, drain countdown, halted flag and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted_q  <= 1'b0;
      stall_q   <= 16'd0;
      flush_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // A cycle that both stalls and flushes counts only as a flush.
      if (br_ev)         flush_q <= sat_inc(flush_q);
      else if (stall_ev) stall_q <= sat_inc(stall_q);

      unique case (state)
        RUN, LDSTALL: begin
          if (br_ev)         state <= RUN;
          else if (stall_ev) state <= STALL_NEXT;
          else if (halt_ev) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end else           state <= RUN;
        end
        DRAIN: begin
          if (br_ev) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
          end else if (drain_cnt <= 2'd1) begin
            state     <= HALT;
            halted_q  <= 1'b1;
            drain_cnt <= 2'd0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs are queued as each step is
// driven and popped for comparison on the following falling edge.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, if_id_en, if_id_flush, id_ex_flush}
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_BR    = 4'b1111;
  localparam logic [3:0] C_DRAIN = 4'b0110;
  localparam logic [3:0] C_HALT  = 4'b0000;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        halted;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_sc, exp_fc;
  exp_t  sb[$];
  string tags[$];

  pipe_ctrl_if bus();

  pipe_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle();
    bus.id_rs1 = 4'd0; bus.id_rs2 = 4'd0; bus.id_use1 = 1'b0; bus.id_use2 = 1'b0;
    bus.id_halt = 1'b0; bus.ex_rd = 4'd0; bus.ex_wen = 1'b0; bus.ex_load = 1'b0;
    bus.mem_rd = 4'd0; bus.mem_wen = 1'b0; bus.ex_br_taken = 1'b0;
  endtask

  // Entered just after a rising edge: queue the expectation, update the
  // counter model for the coming edge, compare on the falling edge.
  task automatic step(input string tag, input logic [3:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic h, input bit sinc, input bit finc);
    exp_t e, got;
    string t;
    e = '{ctl: ctl, fa: fa, fb: fb, halted: h, sc: exp_sc, fc: exp_fc};
    sb.push_back(e);
    tags.push_back(tag);
    if (finc)      exp_fc = (exp_fc == 16'hFFFF) ? exp_fc : exp_fc + 16'd1;
    else if (sinc) exp_sc = (exp_sc == 16'hFFFF) ? exp_sc : exp_sc + 16'd1;
    @(negedge clk);
    got = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush,
           bus.fwd_a, bus.fwd_b, bus.halted, bus.stall_cnt, bus.flush_cnt};
    e = sb.pop_front();
    t = tags.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    exp_sc = 16'd0;
    exp_fc = 16'd0;
    idle();
    step("reset", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    exp_sc = 16'd0;
    exp_fc = 16'd0;
    idle();
    @(posedge clk);
    #1;

    // Reset held with every hazard/branch/halt input active: outputs stay quiet.
    bus.ex_br_taken = 1'b1; bus.ex_rd = 4'd5; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs1 = 4'd5; bus.id_use1 = 1'b1; bus.id_halt = 1'b1;
    step("reset_quiet", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    rst_n = 1'b1;
    step("idle_run", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // R0 and unread sources never hazard.
    bus.ex_rd = 4'd0; bus.ex_wen = 1'b1; bus.id_rs1 = 4'd0; bus.id_use1 = 1'b1;
    step("r0_no_hazard", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    bus.ex_rd = 4'd4; bus.ex_wen = 1'b1; bus.id_rs2 = 4'd4;
    step("unused_src", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // ALU result r3 consumed as rs1, first from EX then from MEM.
    idle();
    bus.ex_rd = 4'd3; bus.ex_wen = 1'b1; bus.id_rs1 = 4'd3; bus.id_use1 = 1'b1;
    step("alu_ex", FWD ? C_RUN : C_STALL, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0, !FWD, 1'b0);
    idle();
    bus.mem_rd = 4'd3; bus.mem_wen = 1'b1; bus.id_rs1 = 4'd3; bus.id_use1 = 1'b1;
    step("alu_mem", FWD ? C_RUN : C_STALL, FWD ? 2'b10 : 2'b00, 2'b00, 1'b0, !FWD, 1'b0);
    idle();
    step("alu_done", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Both stages write r6: EX/MEM must win for both operands.
    bus.ex_rd = 4'd6; bus.ex_wen = 1'b1; bus.mem_rd = 4'd6; bus.mem_wen = 1'b1;
    bus.id_rs1 = 4'd6; bus.id_use1 = 1'b1; bus.id_rs2 = 4'd6; bus.id_use2 = 1'b1;
    step("fwd_prio", FWD ? C_RUN : C_STALL, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00,
         1'b0, !FWD, 1'b0);

    // Load r5 in EX, consumer reads r5 as rs2.
    do_reset();
    bus.ex_rd = 4'd5; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs2 = 4'd5; bus.id_use2 = 1'b1;
    step("load_use", C_STALL, 2'b00, FWD ? 2'b01 : 2'b00, 1'b0, 1'b1, 1'b0);
    idle();
    bus.mem_rd = 4'd5; bus.mem_wen = 1'b1; bus.id_rs2 = 4'd5; bus.id_use2 = 1'b1;
    step("load_after", FWD ? C_RUN : C_STALL, 2'b00, FWD ? 2'b10 : 2'b00, 1'b0, !FWD, 1'b0);
    idle();
    step("load_done", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Taken branch beats a simultaneous load-use.
    do_reset();
    bus.ex_rd = 4'd5; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs2 = 4'd5; bus.id_use2 = 1'b1; bus.ex_br_taken = 1'b1;
    step("br_vs_load", C_BR, 2'b00, FWD ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b1);
    idle();
    step("br_after", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Load-use beats a halt request.
    bus.ex_rd = 4'd2; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs1 = 4'd2; bus.id_use1 = 1'b1; bus.id_halt = 1'b1;
    step("load_over_halt", C_STALL, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    idle();
    step("after_prio", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Halt: three drain cycles, halted on the fourth, then deaf to inputs.
    do_reset();
    bus.id_halt = 1'b1;
    step("halt_accept", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    step("drain1", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("drain2", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("drain3", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("halted", C_HALT, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    bus.ex_br_taken = 1'b1; bus.ex_rd = 4'd7; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs1 = 4'd7; bus.id_use1 = 1'b1; bus.id_halt = 1'b1;
    step("halt_ignores", C_HALT, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    idle();
    step("halt_hold", C_HALT, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

    // Branch two cycles into the drain cancels the halt.
    do_reset();
    bus.id_halt = 1'b1;
    step("halt_accept_b", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    step("drain_b1", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    bus.ex_br_taken = 1'b1;
    step("drain_cancel", C_BR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    idle();
    step("cancel_run", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("cancel_stays", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    do_reset();
`ifndef PIPE_CTRL_FWD_EN
    // Persistent ALU match stalls every cycle: drive stall_cnt to saturation.
    bus.ex_rd = 4'd9; bus.ex_wen = 1'b1; bus.id_rs1 = 4'd9; bus.id_use1 = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    exp_sc = 16'hFFFE;
    step("sat_fffe", C_STALL, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    step("sat_ffff", C_STALL, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    step("sat_hold", C_STALL, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
`endif

    // Non-zero counters, enter DRAIN, then reset mid-drain.
    idle();
    bus.ex_rd = 4'd8; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs1 = 4'd8; bus.id_use1 = 1'b1;
    step("pre_drain_stall", C_STALL, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    idle();
    bus.id_halt = 1'b1;
    step("halt_accept_c", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    step("drain_c1", C_DRAIN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n  = 1'b0;
    exp_sc = 16'd0;
    exp_fc = 16'd0;
    bus.ex_br_taken = 1'b1; bus.ex_rd = 4'd8; bus.ex_wen = 1'b1; bus.ex_load = 1'b1;
    bus.id_rs1 = 4'd8; bus.id_use1 = 1'b1;
    step("reset_mid_drain", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    rst_n = 1'b1;
    step("post_reset_run", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step("post_reset_idle", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Clk  in  1  single clock; all state updates on rising edge.
REQ-002 Rst  in  1  reset, asynchronous, active-low.
REQ-003 id_rs1, id_rs2  in  4 each  source register numbers of the instruction in ID.
REQ-004 id_use1, id_use2  in  1 each  the matching ID source is actually read.
REQ-005 id_halt  in  1  HLT opcode decoded in ID.
REQ-006 ex_rd  in  4; ex_wen  in  1; ex_load  in  1  destination, write enable and load flag of the EX-stage instruction.
REQ-007 mem_rd  in  4; mem_wen  in  1  destination and write enable of the MEM-stage instruction.
REQ-008 ex_br_taken  in  1  branch/jump in EX resolved taken this cycle.
REQ-009 pc_en, if_id_en  out  1 each  PC and IF/ID register load enables.
REQ-010 if_id_flush, id_ex_flush  out  1 each  replace the stage register contents with a bubble (all control bits 0).
REQ-011 fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data.
REQ-012 halted  out  1  pipeline drained and stopped.
REQ-013 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-014 Hazard match (ID source n against stage s) SHALL be: id_use_n and s_wen and s_rd == id_rs_n and s_rd != 0; R0 never creates a hazard.
REQ-015 FSM states SHALL be RUN, LDSTALL, DRAIN, HALT.
REQ-016 Priority in every state except HALT SHALL be: ex_br_taken > load-use > halt request.
REQ-017 ex_br_taken=1 SHALL, combinationally in the same cycle, assert if_id_flush and id_ex_flush and keep pc_en=1; next state RUN; flush_cnt += 1.
REQ-018 RUN with an EX match (either source) and ex_load=1 SHALL hold pc_en=0, if_id_en=0, id_ex_flush=1 for that cycle and go to LDSTALL; stall_cnt += 1.
REQ-019 LDSTALL SHALL last exactly one cycle with pc_en=if_id_en=1 and forwarding from MEM/WB, then return to RUN; load-use stalls are therefore exactly one bubble.
REQ-020 RUN with id_halt=1 and no higher-priority event SHALL go to DRAIN with pc_en=0 and if_id_flush=1; a 2-bit drain counter loads 3.
REQ-021 DRAIN SHALL hold pc_en=0, if_id_flush=1, decrement the counter each cycle and enter HALT when it reaches 0 (halted=1 exactly 4 cycles after id_halt was accepted); ex_br_taken during DRAIN cancels the halt and returns to RUN.
REQ-022 HALT SHALL hold pc_en=if_id_en=0, halted=1, ignore all inputs, and exit only by reset.
REQ-023 Counters SHALL saturate at 16'hFFFF; a stall and a flush in the same cycle increment only flush_cnt.
REQ-024 Forwarding priority SHALL be EX/MEM (01) over MEM/WB (10) when both match.

Reset
REQ-025 Rst low SHALL immediately force state RUN, drain counter 0, stall_cnt=flush_cnt=0, halted=0, flushes 0, fwd_a=fwd_b=00, pc_en=if_id_en=1; reset mid-DRAIN or mid-LDSTALL discards the pending operation.
REQ-026 Release of Rst SHALL take effect on the first rising Clk edge after deassertion; no output glitches to a non-reset value while Rst is low.

Configuration
REQ-027 Macro PIPE_CTRL_FWD_EN defined: fwd_a/fwd_b computed per REQ-011/REQ-024; only load-use causes stalls.
REQ-028 Macro PIPE_CTRL_FWD_EN undefined: fwd_a=fwd_b=00 always; any EX or MEM match (load or not) SHALL stall (pc_en=if_id_en=0, id_ex_flush=1) every cycle the match persists, each cycle counted in stall_cnt.

Verification
REQ-029 ADD r3 in EX (ex_rd=3, ex_wen=1, ex_load=0), ID reads r3 as rs1 -> FWD_EN: fwd_a=01, no stall; without: stall 2 cycles, stall_cnt=2.
REQ-030 LW r5 in EX, ID uses r5 as rs2 -> one cycle pc_en=0, id_ex_flush=1, then fwd_b=10, stall_cnt=1.
REQ-031 ex_br_taken=1 coincident with load-use match -> both flushes asserted, pc_en=1, flush_cnt=1, stall_cnt=0.
REQ-032 id_halt=1 in RUN -> halted=1 four cycles later, pc_en stays 0 until Rst low; counters frozen.
REQ-033 id_halt accepted, ex_br_taken=1 two cycles later -> state RUN, halted never asserted, flush_cnt=1.
REQ-034 Force stall_cnt to 16'hFFFE via 2 further stalls plus one more -> reads 16'hFFFF; Rst low mid-DRAIN -> all outputs at reset values asynchronously.
